// File: rtl/ppu_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_frame_ctrl_if
//  Brief    : Serial source handshake and PPU-side bus of ppu_frame_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
interface ppu_frame_ctrl_if;
    logic       start;
    logic       src_bit;
    logic       src_vld;
    logic       src_rdy;
    logic       ppu_di;
    logic       ppu_di_vld;
    logic [3:0] sym_num;
    logic       busy;
    logic       frame_done;
    logic       err;

    modport master (
        output start, src_bit, src_vld,
        input  src_rdy, ppu_di, ppu_di_vld, sym_num, busy, frame_done, err
    );

    modport slave (
        input  start, src_bit, src_vld,
        output src_rdy, ppu_di, ppu_di_vld, sym_num, busy, frame_done, err
    );
endinterface
`default_nettype wire

// File: rtl/ppu_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_frame_ctrl
//  Brief    : Frames a serial bit stream into PPU frames of FRAME_BITS bits,
//             tags each bit with its OFDM symbol index and aborts on long stalls.
//             Optional macro PPU_CTRL_STATS_EN adds frame/abort counters.
//  Revision : 1.0  initial release
// ============================================================================
module ppu_frame_ctrl #(
    parameter int FRAME_BITS = 8640,
    parameter int SYM_BITS   = 576,
    parameter int GAP_CYCLES = 4,
    parameter int STALL_MAX  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    ppu_frame_ctrl_if.slave bus
`ifdef PPU_CTRL_STATS_EN
    ,
    output logic [15:0]     frame_cnt,
    output logic [7:0]      abort_cnt
`endif
);

    localparam int c_NSYM = FRAME_BITS / SYM_BITS;
    localparam int c_BW   = (SYM_BITS > 1)   ? $clog2(SYM_BITS)   : 1;
    localparam int c_SW   = (STALL_MAX > 1)  ? $clog2(STALL_MAX)  : 1;
    localparam int c_GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(SYM_BITS - 1);
    localparam logic [3:0]      c_SYM_LAST   = 4'(c_NSYM - 1);
    localparam logic [c_SW-1:0] c_STALL_LAST = c_SW'(STALL_MAX - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic [c_BW-1:0] bit_cnt_q,   bit_cnt_d;
    logic [3:0]      sym_cnt_q,   sym_cnt_d;
    logic [c_SW-1:0] stall_cnt_q, stall_cnt_d;
    logic [c_GW-1:0] gap_cnt_q,   gap_cnt_d;
    logic            ppu_di_q,    ppu_di_d;
    logic            ppu_di_vld_q, ppu_di_vld_d;
    logic [3:0]      sym_num_q,   sym_num_d;
    logic            frame_done_q, frame_done_d;
    logic            err_q,       err_d;
    logic            w_src_rdy;
    logic            w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            ppu_di_q     <= 1'b0;
            ppu_di_vld_q <= 1'b0;
            sym_num_q    <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            ppu_di_q     <= ppu_di_d;
            ppu_di_vld_q <= ppu_di_vld_d;
            sym_num_q    <= sym_num_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        ppu_di_d     = ppu_di_q;
        ppu_di_vld_d = 1'b0;
        sym_num_d    = sym_num_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        w_src_rdy    = (state_q == S_RUN);
        w_accept     = w_src_rdy & bus.src_vld;

        case (state_q)
            S_IDLE: begin
                bit_cnt_d   = '0;
                sym_cnt_d   = '0;
                stall_cnt_d = '0;
                gap_cnt_d   = '0;
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (w_accept) begin
                    // sym_num is captured from the count before this bit advances it
                    ppu_di_d     = bus.src_bit;
                    ppu_di_vld_d = 1'b1;
                    sym_num_d    = sym_cnt_q;
                    stall_cnt_d  = '0;
                    if (bit_cnt_q == c_BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (sym_cnt_q == c_SYM_LAST) begin
                            sym_cnt_d    = '0;
                            gap_cnt_d    = '0;
                            frame_done_d = 1'b1;
                            state_d      = S_GAP;
                        end else begin
                            sym_cnt_d = sym_cnt_q + 4'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + c_BW'(1);
                    end
                end else if (stall_cnt_q == c_STALL_LAST) begin
                    // this starved cycle brings the stall count to STALL_MAX
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                    bit_cnt_d   = '0;
                    sym_cnt_d   = '0;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + c_SW'(1);
                end
            end

            S_GAP: begin
                if (gap_cnt_q == c_GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + c_GW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.src_rdy    = w_src_rdy;
    assign bus.ppu_di     = ppu_di_q;
    assign bus.ppu_di_vld = ppu_di_vld_q;
    assign bus.sym_num    = sym_num_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

`ifdef PPU_CTRL_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [7:0]  abort_cnt_q;

    // counted from the next-state pulses so totals move with the visible pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (frame_done_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (err_d) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;
`else
    // statistics counters are not built
`endif

endmodule
`default_nettype wire
